// File: rtl/ysyx_23060077_riscv_id_imm_pipe_if.sv
// Handshake bundle for the ID immediate stage: upstream instruction stream in,
// decoded entry (inst, imm, type) out. The stage connects through the slave modport.
interface ysyx_23060077_riscv_id_imm_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_inst;
  logic [DATA_WIDTH-1:0] out_imm;
  logic [2:0]            out_imm_type;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_inst, out_imm, out_imm_type
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_inst, out_imm, out_imm_type
  );
endinterface

// File: rtl/ysyx_23060077_riscv_id_imm_pipe.sv
// Registered immediate generator for the ID stage: decodes the immediate of each
// accepted instruction and holds results in a two-entry skid buffer (main M, skid S).
module ysyx_23060077_riscv_id_imm_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter bit RV64       = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  ysyx_23060077_riscv_id_imm_pipe_if.slave     bus
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  state_e                r_state;
  state_e                w_next;
  logic                  r_in_ready;

  logic [31:0]           r_m_inst;
  logic [DATA_WIDTH-1:0] r_m_imm;
  imm_type_e             r_m_type;
  logic [31:0]           r_s_inst;
  logic [DATA_WIDTH-1:0] r_s_imm;
  imm_type_e             r_s_type;

  logic [DATA_WIDTH-1:0] w_dec_imm;
  imm_type_e             w_dec_type;
  logic                  w_accept;
  logic                  w_xfer;
  logic                  w_load_m;
  logic                  w_load_s;
  logic                  w_s_to_m;
  logic [31:0]           w_i;

  assign w_i = bus.in_inst;

  // Sign extension comes from casting a signed field up to DATA_WIDTH.
  always_comb begin
    w_dec_imm  = '0;
    w_dec_type = IMM_NONE;
    case (w_i[6:0])
      7'b0110111, 7'b0010111: begin
        w_dec_type = IMM_U;
        w_dec_imm  = DATA_WIDTH'($signed({w_i[31:12], 12'b0}));
      end
      7'b1101111: begin
        w_dec_type = IMM_J;
        w_dec_imm  = DATA_WIDTH'($signed({w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0}));
      end
      7'b1100111, 7'b0000011, 7'b0010011: begin
        w_dec_type = IMM_I;
        w_dec_imm  = DATA_WIDTH'($signed(w_i[31:20]));
      end
      7'b0011011: begin
        if (RV64) begin
          w_dec_type = IMM_I;
          w_dec_imm  = DATA_WIDTH'($signed(w_i[31:20]));
        end
      end
      7'b1100011: begin
        w_dec_type = IMM_B;
        w_dec_imm  = DATA_WIDTH'($signed({w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0}));
      end
      7'b0100011: begin
        w_dec_type = IMM_S;
        w_dec_imm  = DATA_WIDTH'($signed({w_i[31:25], w_i[11:7]}));
      end
      7'b1110011: begin
        if (w_i[14]) begin
          w_dec_type = IMM_Z;
          w_dec_imm  = DATA_WIDTH'(w_i[19:15]);
        end else begin
          w_dec_type = IMM_I;
          w_dec_imm  = DATA_WIDTH'($signed(w_i[31:20]));
        end
      end
      default: begin
        w_dec_imm  = '0;
        w_dec_type = IMM_NONE;
      end
    endcase
  end

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_xfer   = (r_state != ST_EMPTY) & bus.out_ready;

  always_comb begin
    w_next   = r_state;
    w_load_m = 1'b0;
    w_load_s = 1'b0;
    w_s_to_m = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next   = ST_ONE;
          w_load_m = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_accept, w_xfer})
          2'b11: w_load_m = 1'b1;
          2'b10: begin
            w_next   = ST_FULL;
            w_load_s = 1'b1;
          end
          2'b01: w_next = ST_EMPTY;
          default: w_next = ST_ONE;
        endcase
      end
      ST_FULL: begin
        if (w_xfer) begin
          w_next   = ST_ONE;
          w_s_to_m = 1'b1;
        end
      end
      default: w_next = ST_EMPTY;
    endcase
  end

  // Data loads are not gated by flush; the cleared valid bits make them invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_m_inst   <= '0;
      r_m_imm    <= '0;
      r_m_type   <= IMM_NONE;
      r_s_inst   <= '0;
      r_s_imm    <= '0;
      r_s_type   <= IMM_NONE;
    end else begin
      if (flush) begin
        r_state    <= ST_EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_next;
        r_in_ready <= (w_next != ST_FULL);
      end
      if (w_load_m) begin
        r_m_inst <= w_i;
        r_m_imm  <= w_dec_imm;
        r_m_type <= w_dec_type;
      end else if (w_s_to_m) begin
        r_m_inst <= r_s_inst;
        r_m_imm  <= r_s_imm;
        r_m_type <= r_s_type;
      end
      if (w_load_s) begin
        r_s_inst <= w_i;
        r_s_imm  <= w_dec_imm;
        r_s_type <= w_dec_type;
      end
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = (r_state != ST_EMPTY);
  assign bus.out_inst     = r_m_inst;
  assign bus.out_imm      = r_m_imm;
  assign bus.out_imm_type = r_m_type;

endmodule

// File: tb/tb_ysyx_23060077_riscv_id_imm_pipe.sv
// Scoreboard bench: an RV64 (64-bit) and an RV32 (32-bit) instance receive identical
// stimulus; expected entries come from an arithmetic reference decoder.
module tb_ysyx_23060077_riscv_id_imm_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  bit   started = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ysyx_23060077_riscv_id_imm_pipe_if #(.DATA_WIDTH(64)) b64 ();
  ysyx_23060077_riscv_id_imm_pipe_if #(.DATA_WIDTH(32)) b32 ();

  ysyx_23060077_riscv_id_imm_pipe #(.DATA_WIDTH(64), .RV64(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b64.slave)
  );
  ysyx_23060077_riscv_id_imm_pipe #(.DATA_WIDTH(32), .RV64(1'b0)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b32.slave)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  ty;
  } ent_t;

  ent_t q64[$];
  ent_t q32[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: immediates as signed integers built from field weights.
  function automatic ent_t ref_dec(input logic [31:0] i, input bit rv64);
    longint v;
    ent_t   e;
    v    = 0;
    e.ty = 3'd0;
    case (i[6:0])
      7'h37, 7'h17: begin
        e.ty = 3'd4;
        v = longint'(i[31:12]) * 4096;
        if (i[31]) v = v - 64'sh1_0000_0000;
      end
      7'h6F: begin
        e.ty = 3'd5;
        v = longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096
          + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= 1048576) v = v - 2097152;
      end
      7'h67, 7'h03, 7'h13, 7'h1B: begin
        if (i[6:0] != 7'h1B || rv64) begin
          e.ty = 3'd1;
          v = longint'(i[31:20]);
          if (v >= 2048) v = v - 4096;
        end
      end
      7'h63: begin
        e.ty = 3'd3;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v = v - 8192;
      end
      7'h23: begin
        e.ty = 3'd2;
        v = longint'(i[31:25]) * 32 + longint'(i[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h73: begin
        if (i[14]) begin
          e.ty = 3'd6;
          v = longint'(i[19:15]);
        end else begin
          e.ty = 3'd1;
          v = longint'(i[31:20]);
          if (v >= 2048) v = v - 4096;
        end
      end
      default: v = 0;
    endcase
    e.inst = i;
    e.imm  = 64'(v);
    if (!rv64) e.imm = {32'b0, e.imm[31:0]};
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 13))
      0:  r[6:0] = 7'h37;
      1:  r[6:0] = 7'h17;
      2:  r[6:0] = 7'h6F;
      3:  r[6:0] = 7'h67;
      4:  r[6:0] = 7'h03;
      5:  r[6:0] = 7'h13;
      6:  r[6:0] = 7'h1B;
      7:  r[6:0] = 7'h63;
      8:  r[6:0] = 7'h23;
      9:  r[6:0] = 7'h73;
      10: r[6:0] = 7'h33;
      11: r[6:0] = 7'h3B;
      12: r[6:0] = 7'h0F;
      default: ;
    endcase
    return r;
  endfunction

  // Monitors: occupancy vs scoreboard depth, then pop on transfer, push on accept.
  always @(negedge clk) begin
    ent_t e;
    if (started) begin
      chk("m64_occupancy_valid", 64'(b64.out_valid), 64'(q64.size() != 0));
      chk("m64_in_ready", 64'(b64.in_ready), 64'(q64.size() < 2));
      if (!rst && b64.out_valid && b64.out_ready) begin
        if (q64.size() == 0) chk("m64_unexpected_out", 64'(1), 64'(0));
        else begin
          e = q64.pop_front();
          chk("m64_inst", 64'(b64.out_inst), 64'(e.inst));
          chk("m64_imm", b64.out_imm, e.imm);
          chk("m64_type", 64'(b64.out_imm_type), 64'(e.ty));
        end
      end
      if (rst || flush) q64.delete();
      else if (b64.in_valid && b64.in_ready) q64.push_back(ref_dec(b64.in_inst, 1'b1));
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (started) begin
      chk("m32_occupancy_valid", 64'(b32.out_valid), 64'(q32.size() != 0));
      chk("m32_in_ready", 64'(b32.in_ready), 64'(q32.size() < 2));
      if (!rst && b32.out_valid && b32.out_ready) begin
        if (q32.size() == 0) chk("m32_unexpected_out", 64'(1), 64'(0));
        else begin
          e = q32.pop_front();
          chk("m32_inst", 64'(b32.out_inst), 64'(e.inst));
          chk("m32_imm", 64'(b32.out_imm), e.imm);
          chk("m32_type", 64'(b32.out_imm_type), 64'(e.ty));
        end
      end
      if (rst || flush) q32.delete();
      else if (b32.in_valid && b32.in_ready) q32.push_back(ref_dec(b32.in_inst, 1'b0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [31:0] inst);
    b64.in_valid = v; b64.in_inst = inst;
    b32.in_valid = v; b32.in_inst = inst;
  endtask

  task automatic set_ordy(input bit r);
    b64.out_ready = r;
    b32.out_ready = r;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid64"}, 64'(b64.out_valid), 64'(0));
    chk({tag, "_valid32"}, 64'(b32.out_valid), 64'(0));
    chk({tag, "_ready64"}, 64'(b64.in_ready), 64'(1));
    chk({tag, "_ready32"}, 64'(b32.in_ready), 64'(1));
  endtask

  task automatic chk_zero_data(input string tag);
    chk({tag, "_inst64"}, 64'(b64.out_inst), 64'(0));
    chk({tag, "_imm64"}, b64.out_imm, 64'(0));
    chk({tag, "_type64"}, 64'(b64.out_imm_type), 64'(0));
    chk({tag, "_inst32"}, 64'(b32.out_inst), 64'(0));
    chk({tag, "_imm32"}, 64'(b32.out_imm), 64'(0));
    chk({tag, "_type32"}, 64'(b32.out_imm_type), 64'(0));
  endtask

  // Stage must be empty on entry; leaves it empty.
  task automatic send_one(input string tag, input logic [31:0] inst,
                          input logic [63:0] e64, input logic [2:0] t64,
                          input logic [31:0] e32, input logic [2:0] t32);
    set_ordy(1'b1);
    set_in(1'b1, inst);
    cyc();
    set_in(1'b0, '0);
    chk({tag, "_valid"}, 64'(b64.out_valid & b32.out_valid), 64'(1));
    chk({tag, "_imm64"}, b64.out_imm, e64);
    chk({tag, "_type64"}, 64'(b64.out_imm_type), 64'(t64));
    chk({tag, "_imm32"}, 64'(b32.out_imm), 64'(e32));
    chk({tag, "_type32"}, 64'(b32.out_imm_type), 64'(t32));
    cyc();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    set_in(1'b0, '0);
    set_ordy(1'b1);
    while ((b64.out_valid || b32.out_valid) && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, "_drained"}, 64'(b64.out_valid | b32.out_valid), 64'(0));
  endtask

  // mode 0: fixed out_ready pattern, 1: always ready, 2: random valid/ready/flush
  task automatic stream(input string tag, input int n, input int mode);
    bit          pat [8];
    int          sent, budget;
    bit          v, r, fl, acc;
    logic [31:0] cur;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    sent = 0;
    budget = 0;
    cur = rand_inst();
    while (sent < n && budget < n * 10 + 20) begin
      r  = (mode == 0) ? pat[budget % 8] : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      v  = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      fl = (mode == 2) && ($urandom_range(0, 31) == 0);
      set_ordy(r);
      set_in(v, cur);
      flush = fl;
      acc = v && b64.in_ready && !fl;
      cyc();
      if (acc) begin
        sent++;
        cur = rand_inst();
      end
      budget++;
    end
    flush = 1'b0;
    chk({tag, "_all_accepted"}, 64'(sent), 64'(n));
    drain(tag);
  endtask

  task automatic fill_full();
    set_ordy(1'b0);
    set_in(1'b1, rand_inst());
    cyc();
    set_in(1'b1, rand_inst());
    cyc();
    set_in(1'b0, '0);
    chk("full_in_ready_low", 64'(b64.in_ready | b32.in_ready), 64'(0));
    chk("full_out_valid", 64'(b64.out_valid & b32.out_valid), 64'(1));
  endtask

  initial begin
    int run;
    set_in(1'b0, '0);
    set_ordy(1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    chk_zero_data("reset");
    rst = 1'b0;
    started = 1'b1;

    send_one("addi_m1", 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 32'hFFFF_FFFF, 3'd1);
    send_one("lui_neg", 32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 32'h8000_0000, 3'd4);
    send_one("beq_m4", 32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 32'hFFFF_FFFC, 3'd3);
    send_one("jal_4", 32'h0040006F, 64'd4, 3'd5, 32'd4, 3'd5);
    send_one("csrrwi", 32'h3002D073, 64'd5, 3'd6, 32'd5, 3'd6);
    send_one("add", 32'h00000033, 64'd0, 3'd0, 32'd0, 3'd0);
    send_one("addiw", 32'hFFF0009B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 32'd0, 3'd0);

    stream("bp_pattern", 8, 0);

    set_ordy(1'b1);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, rand_inst());
      cyc();
      if (b64.out_valid && b32.out_valid) run++;
    end
    set_in(1'b0, '0);
    chk("fullrate_run", 64'(run), 64'(16));
    cyc();
    chk("fullrate_tail", 64'(b64.out_valid | b32.out_valid), 64'(0));

    fill_full();
    flush = 1'b1;
    set_in(1'b1, 32'hDEAD_0013);
    cyc();
    flush = 1'b0;
    set_in(1'b0, '0);
    chk_idle_zero("flush");
    set_ordy(1'b1);
    cyc();
    cyc();
    chk("flush_nothing_after", 64'(b64.out_valid | b32.out_valid), 64'(0));

    fill_full();
    rst = 1'b1;
    set_in(1'b1, 32'hBEEF_0013);
    cyc();
    rst = 1'b0;
    set_in(1'b0, '0);
    chk_idle_zero("rst_mid");
    chk_zero_data("rst_mid");
    set_ordy(1'b1);
    cyc();
    cyc();
    chk("rst_nothing_after", 64'(b64.out_valid | b32.out_valid), 64'(0));

    stream("random", 200, 2);
    stream("burst", 30, 1);

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_23060077_riscv_id_imm_pipe.md
# ysyx_23060077_riscv_id_imm_pipe

Registered immediate-generation stage for the ID pipeline. It accepts one 32-bit instruction per cycle over a valid/ready handshake. It produces the sign- or zero-extended immediate, an immediate-type code and the instruction itself, delayed by one cycle. It replaces the purely combinational extractor in the decode path: it is parametrised for RV32/RV64, adds CSR zero-extended immediates and RV64 `*W` opcodes, and decouples decode from EX backpressure with a two-entry skid buffer.

## Interface
- `DATA_WIDTH`, 32, datapath width (XLEN). Only 32 and 64 are legal. Immediates are extended to this width.
- `RV64`, 0, when 1, opcodes OP_IMM_32 (0011011) and OP_32 (0111011) are decoded. Requires `DATA_WIDTH`=64.
- `clk`  in  1  clock. All state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  drops all buffered entries. Synchronous.
- `in_valid`  in  1  `in_inst` is valid.
- `in_ready`  out  1  the stage can accept an instruction. Driven directly from a register.
- `in_inst`  in  32  instruction word.
- `out_valid`  out  1  the output entry is valid.
- `out_ready`  in  1  the consumer accepts the entry.
- `out_inst`  out  32  instruction passed through.
- `out_imm`  out  `DATA_WIDTH`  extended immediate.
- `out_imm_type`  out  3  immediate type: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm).

## Operation
- Decode is on `in_inst[6:0]`. The result is computed combinationally and captured when the instruction is accepted.
  - LUI, AUIPC: U-type. Immediate is `{inst[31:12], 12'b0}`, sign-extended from bit 31. For RV64, 0x80000000 becomes 0xFFFF_FFFF_8000_0000.
  - JAL: J-type. 21-bit immediate `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`, sign-extended.
  - JALR, LOAD, OP_IMM: I-type. `inst[31:20]` sign-extended.
  - OP_IMM_32 (only when `RV64`=1): I-type. `inst[31:20]` sign-extended.
  - BRANCH: B-type. 13-bit immediate `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`, sign-extended.
  - STORE: S-type. `{inst[31:25], inst[11:7]}` sign-extended.
  - SYS with `inst[14]`=1 (CSRRWI, CSRRSI, CSRRCI): Z-type. `inst[19:15]` zero-extended.
  - SYS with `inst[14]`=0: I-type. Covers ECALL, EBREAK, MRET and CSR register forms.
  - OP, OP_32, FENCE, and any undefined opcode: NONE, immediate 0.
  - OP_IMM_32 and OP_32 when `RV64`=0: NONE, immediate 0.
- Storage is two entries: a main register M, which drives the `out_*` ports, and a skid register S. Each entry holds inst, imm and type.
- The state machine follows from the two valid bits:
  - EMPTY (M=0, S=0) → ONE on accept.
  - ONE (M=1, S=0):
    - stays ONE on accept with output transfer.
    - → EMPTY on output transfer without accept.
    - → FULL on accept without output transfer. The new entry goes into S.
  - FULL (M=1, S=1) → ONE on output transfer. S moves into M.
- Accept means `in_valid & in_ready`. Output transfer means `out_valid & out_ready`.
- `in_ready` = !S_valid, held in a flop. It deasserts only in FULL, so no entry is ever lost.
- Entries leave in order. Per entry, the imm and type delivered are exactly those decoded from that entry's inst.

## Timing
- Latency: an instruction accepted at edge N is presented at edge N, with `out_valid`=1 in cycle N+1 when the stage was empty. Throughput is 1 per cycle while `out_ready`=1.
- Reset (`rst`=1 at an edge): M_valid=0, S_valid=0, `in_ready`=1. `out_inst`, `out_imm` and `out_imm_type` are all 0.
- Reset mid-operation discards both entries. Any handshake in the reset cycle is ignored.
- `flush`=1: same effect as reset on the valid bits and `in_ready`.
  - An `in_valid` arriving in the flush cycle is dropped, even though `in_ready` was 1.
  - An output transfer in the flush cycle still counts for the consumer, whose own flush logic handles it.
- Simultaneous in FULL: `out_ready`=1 and `in_valid`=1. S moves to M and `in_ready` rises next cycle. The input is not accepted, because `in_ready`=0 in that cycle.
- Simultaneous in ONE: accept and output transfer together. M is reloaded with the new entry and S stays empty.
- Data registers may update without reset when valid=0. The reset values above are still required.

## Test plan
- Sign-extension, `DATA_WIDTH`=64, `RV64`=1:
  - 0xFFF00093 (addi x1,x0,-1) → imm 0xFFFF_FFFF_FFFF_FFFF, type 1.
  - 0x800002B7 (lui) → 0xFFFF_FFFF_8000_0000, type 4.
- Branch/jump, `DATA_WIDTH`=32:
  - 0xFE000EE3 (beq x0,x0,-4) → imm 0xFFFF_FFFC, type 3.
  - 0x0040006F (jal x0,4) → imm 4, type 5.
- CSR and misc:
  - 0x3002D073 (csrrwi x0,mstatus,5) → imm 5, type 6.
  - 0x00000033 (add) → imm 0, type 0.
  - With `RV64`=0, 0xFFF0009B → imm 0, type 0.
- Backpressure:
  - Stream 8 instructions while `out_ready` follows the pattern 1,0,0,1,1,0,1,1.
  - Required: `in_ready` falls only after two entries are held; outputs stay in order with none lost or duplicated; imm matches a reference model on every transfer.
- Flush/reset:
  - In FULL, assert `flush` together with `in_valid`=1. Next cycle `out_valid`=0 and `in_ready`=1, and the flushed instruction never appears.
  - Repeat with `rst`. All outputs read 0.
- Full-rate: 16 back-to-back instructions with `out_ready` held at 1 produce 16 consecutive `out_valid` cycles starting one cycle after the first accept.
